// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 scan bytes into game direction, start and reset commands.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES    = 16_777_216
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       scan_valid,
    input  logic [7:0] scan_byte,
    input  logic       move_ack,
    output logic [3:0] direction,
    output logic       start,
    output logic       reset_req,
    output logic [5:0] keys_down
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD     = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    dir_q, dir_d;
    logic [5:0]    keys_q, keys_d;
    logic [HW-1:0] st_cnt_q, st_cnt_d;
    logic [HW-1:0] rs_cnt_q, rs_cnt_d;
    logic          is_key, is_break, ext;
    logic [5:0]    hit, fresh;
    logic [3:0]    dir_acked;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        is_key   = 1'b0;
        is_break = 1'b0;
        ext      = 1'b0;
        if (scan_valid) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    state_d = scan_byte == 8'hE0 ? EXT : scan_byte == 8'hF0 ? BRK : IDLE;
                    is_key  = scan_byte != 8'hE0 && scan_byte != 8'hF0;
                end
                EXT: begin
                    state_d = scan_byte == 8'hF0 ? EXT_BRK : scan_byte == 8'hE0 ? EXT : IDLE;
                    is_key  = scan_byte != 8'hE0 && scan_byte != 8'hF0;
                    ext     = 1'b1;
                end
                BRK: begin
                    state_d  = IDLE;
                    is_key   = 1'b1;
                    is_break = 1'b1;
                end
                default: begin
                    state_d  = IDLE;
                    is_key   = 1'b1;
                    is_break = 1'b1;
                    ext      = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            // a stale prefix must not attach itself to a much later byte
            state_d = tmo_q == TMO_LAST ? IDLE : state_q;
            tmo_d   = tmo_q == TMO_LAST ? '0 : tmo_q + 1'b1;
        end
    end

    always_comb begin
        hit       = !is_key ? 6'b0 :
                    ext ? {scan_byte == 8'h75, scan_byte == 8'h72, scan_byte == 8'h6B, scan_byte == 8'h74, 2'b00} :
                          {4'b0000, scan_byte == 8'h1B, scan_byte == 8'h76};
        fresh     = is_break ? 6'b0 : hit & ~keys_q;
        keys_d    = is_break ? keys_q & ~hit : keys_q | hit;
        dir_acked = move_ack ? 4'b0 : dir_q;
        dir_d     = (|fresh[5:2] && dir_acked == 4'b0) ? fresh[5:2] : dir_acked;
        st_cnt_d  = fresh[1] ? HOLD : st_cnt_q != '0 ? st_cnt_q - 1'b1 : st_cnt_q;
        rs_cnt_d  = fresh[0] ? HOLD : rs_cnt_q != '0 ? rs_cnt_q - 1'b1 : rs_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            dir_q    <= '0;
            keys_q   <= '0;
            st_cnt_q <= '0;
            rs_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            dir_q    <= dir_d;
            keys_q   <= keys_d;
            st_cnt_q <= st_cnt_d;
            rs_cnt_q <= rs_cnt_d;
        end
    end

    assign direction = dir_q;
    assign keys_down = keys_q;
    assign start     = keys_q[1] | (st_cnt_q != '0);
    assign reset_req = keys_q[0] | (rs_cnt_q != '0);
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed byte sequences against hand-computed decoder outputs.
module tb_ps2_key_decoder;
    logic       clock = 1'b0;
    logic       resetn, scan_valid, move_ack;
    logic [7:0] scan_byte;
    logic [3:0] direction;
    logic       start, reset_req;
    logic [5:0] keys_down;
    int         n_vec = 0, n_err = 0, start_cnt = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(100), .HOLD_CYCLES(64)) dut (
        .clock(clock), .resetn(resetn), .scan_valid(scan_valid), .scan_byte(scan_byte),
        .move_ack(move_ack), .direction(direction), .start(start), .reset_req(reset_req),
        .keys_down(keys_down)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (start) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        scan_valid = 1'b1;
        scan_byte  = b;
        @(negedge clock);
        scan_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clock);
        move_ack = 1'b1;
        @(negedge clock);
        move_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; scan_valid = 1'b0; move_ack = 1'b0; scan_byte = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_dir", direction, 4'b0000);
        chk("rst_start", start, 1'b0);
        chk("rst_rreq", reset_req, 1'b0);
        chk("rst_keys", keys_down, 6'b0);
        resetn = 1'b1;

        send(8'hE0); send(8'h75);
        chk("up_dir", direction, 4'b1000);
        chk("up_keys", keys_down, 6'b100000);
        ack();
        chk("up_ack", direction, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_rel", keys_down, 6'b0);

        send(8'hE0); send(8'h6B);
        chk("left_dir", direction, 4'b0010);
        send(8'hE0); send(8'h74);
        chk("drop_dir", direction, 4'b0010);
        chk("drop_keys", keys_down, 6'b001100);
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("lr_rel", keys_down, 6'b0);
        ack();
        send(8'hE0); send(8'h74);
        chk("right_dir", direction, 4'b0001);
        ack();
        send(8'hE0); send(8'hF0); send(8'h74);

        send(8'hE0); send(8'h72);
        chk("down_dir", direction, 4'b0100);
        ack();
        send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h72);
        chk("typematic", direction, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h72);
        send(8'hE0); send(8'h72);
        chk("down_again", direction, 4'b0100);
        ack();
        send(8'hE0); send(8'hF0); send(8'h72);

        send(8'hE0); send(8'hE0); send(8'h75);
        chk("e0_repeat", direction, 4'b1000);
        ack();
        send(8'hE0); send(8'hF0); send(8'h75);

        start_cnt = 0;
        send(8'h1B);
        chk("start_on", start, 1'b1);
        chk("s_key", keys_down, 6'b000010);
        repeat (10) @(negedge clock);
        send(8'hF0); send(8'h1B);
        chk("s_rel", keys_down, 6'b0);
        chk("start_hold", start, 1'b1);
        for (int i = 0; i < 200 && start; i++) @(negedge clock);
        chk("start_len", start_cnt, 64);

        send(8'hE0);
        repeat (50) @(negedge clock);
        send(8'h75);
        chk("pre_tmo", direction, 4'b1000);
        ack();
        send(8'hE0); send(8'hF0); send(8'h75);

        send(8'hE0);
        repeat (120) @(negedge clock);
        send(8'h75);
        chk("tmo_dir", direction, 4'b0000);
        chk("tmo_keys", keys_down, 6'b0);
        send(8'h76);
        chk("esc_rreq", reset_req, 1'b1);
        send(8'h1B);
        chk("both_st", start, 1'b1);
        chk("both_keys", keys_down, 6'b000011);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h76);
        chk("esc_hold", reset_req, 1'b1);
        repeat (80) @(negedge clock);
        chk("both_off", {start, reset_req}, 2'b00);

        send(8'hF0); send(8'hF0); send(8'h1B);
        chk("f0f0_make", keys_down, 6'b000010);
        send(8'hF0); send(8'h1B);
        repeat (80) @(negedge clock);

        send(8'h76); send(8'hE0); send(8'hF0);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("mid_rst", {direction, start, reset_req, keys_down}, 12'h000);
        send(8'h75);
        chk("post_rst_dir", direction, 4'b0000);
        send(8'hF0); send(8'h76);
        chk("orphan_brk", {reset_req, keys_down}, 7'b0);
        send(8'hE0); send(8'h75);
        chk("post_rst_up", direction, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
